// File: rtl/hazard_ctrl_if.sv
// Decode/writeback/execute sideband bundle for the hazard controller.
// master drives the pipeline-side inputs; slave is the controller itself.
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             dec_valid_i;
    logic [6:0]       dec_opcode_i;
    logic [4:0]       dec_rd_i;
    logic [4:0]       dec_rs1_i;
    logic [4:0]       dec_rs2_i;
    logic             wb_valid_i;
    logic [4:0]       wb_rd_i;
    logic             ex_redirect_i;
    logic             issue_o;
    logic             stall_o;
    logic             flush_o;
    logic [31:0]      busy_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        output dec_valid_i, dec_opcode_i, dec_rd_i, dec_rs1_i, dec_rs2_i,
        output wb_valid_i, wb_rd_i, ex_redirect_i,
        input  issue_o, stall_o, flush_o, busy_o, stall_cnt_o
    );

    modport slave (
        input  dec_valid_i, dec_opcode_i, dec_rd_i, dec_rs1_i, dec_rs2_i,
        input  wb_valid_i, wb_rd_i, ex_redirect_i,
        output issue_o, stall_o, flush_o, busy_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: register busy scoreboard with RAW/WAW stall
// detection, plus a post-redirect flush sequence.
module hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 32
) (
    input logic         clk,
    input logic         rst,
    hazard_ctrl_if.slave bus
);
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES);

    typedef enum logic {StRun, StFlush} state_e;

    state_e           state_q, state_d;
    logic [2:0]       fcnt_q, fcnt_d;
    logic [31:0]      busy_q, busy_d;
    logic [CNT_W-1:0] scnt_q, scnt_d;

    logic        use_rs1, use_rs2, wr_rd, hazard;
    logic        issue, stall, flush;
    logic [31:0] wb_mask, eff_busy;

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        wr_rd   = 1'b0;
        case (bus.dec_opcode_i)
            OpLui, OpAuipc, OpJal: wr_rd = 1'b1;
            OpJalr, OpLoad, OpImm: begin
                use_rs1 = 1'b1;
                wr_rd   = 1'b1;
            end
            OpBranch, OpStore: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OpReg: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                wr_rd   = 1'b1;
            end
            default: ;
        endcase
    end

    // Writeback this cycle is visible to decode through the register file bypass.
    always_comb begin
        wb_mask  = bus.wb_valid_i ? (32'd1 << bus.wb_rd_i) : 32'd0;
        eff_busy = busy_q & ~wb_mask;
        hazard   = bus.dec_valid_i &
                   ((use_rs1 & eff_busy[bus.dec_rs1_i]) |
                    (use_rs2 & eff_busy[bus.dec_rs2_i]) |
                    (wr_rd   & eff_busy[bus.dec_rd_i]));
    end

    always_comb begin
        issue   = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        state_d = state_q;
        fcnt_d  = fcnt_q;
        if (!rst) begin
            case (state_q)
                StRun: begin
                    if (bus.ex_redirect_i) begin
                        flush = 1'b1;
                        if (FLUSH_CYCLES != 0) begin
                            state_d = StFlush;
                            fcnt_d  = FlushLoad;
                        end
                    end else if (hazard) begin
                        stall = 1'b1;
                    end else begin
                        issue = bus.dec_valid_i;
                    end
                end
                StFlush: begin
                    flush = 1'b1;
                    if (bus.ex_redirect_i) begin
                        fcnt_d = FlushLoad;
                    end else if (fcnt_q == 3'd1) begin
                        state_d = StRun;
                    end else begin
                        fcnt_d = fcnt_q - 3'd1;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    // Set after clear so a same-cycle writeback and reissue leaves the bit busy.
    always_comb begin
        busy_d = eff_busy;
        if (issue && wr_rd && (bus.dec_rd_i != 5'd0)) begin
            busy_d = busy_d | (32'd1 << bus.dec_rd_i);
        end
        busy_d[0] = 1'b0;
        scnt_d    = (stall && (scnt_q != {CNT_W{1'b1}})) ? scnt_q + CNT_W'(1) : scnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            fcnt_q  <= 3'd0;
            busy_q  <= 32'd0;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            busy_q  <= busy_d;
            scnt_q  <= scnt_d;
        end
    end

    assign bus.issue_o     = issue;
    assign bus.stall_o     = stall;
    assign bus.flush_o     = flush;
    assign bus.busy_o      = busy_q;
    assign bus.stall_cnt_o = scnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic,
// all compared each cycle against a set-based scoreboard model.
module tb_hazard_ctrl;
    localparam int unsigned FC = 1;
    localparam int unsigned CW = 4;

    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [6:0] FENCE  = 7'b0001111;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CW)) bus ();
    hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;

    // Model: set of pending destination registers, remaining forced-flush cycles, stall count.
    bit m_busy[32];
    int m_flush_rem = 0;
    int m_scnt      = 0;

    logic        s_issue, s_stall, s_flush;
    logic [31:0] s_busy;
    logic [CW-1:0] s_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic step(input bit v, input logic [6:0] op, input int rd, input int rs1,
                        input int rs2, input bit wbv = 0, input int wbrd = 0,
                        input bit red = 0);
        bit r1, r2, wr, haz, e_issue, e_stall, e_flush;
        bit free_busy[32];
        logic [31:0] e_busy;
        bus.dec_valid_i   = v;
        bus.dec_opcode_i  = op;
        bus.dec_rd_i      = 5'(rd);
        bus.dec_rs1_i     = 5'(rs1);
        bus.dec_rs2_i     = 5'(rs2);
        bus.wb_valid_i    = wbv;
        bus.wb_rd_i       = 5'(wbrd);
        bus.ex_redirect_i = red;
        @(negedge clk);
        r1 = op inside {JALR, BRANCH, LOAD, STORE, OPIMM, OP};
        r2 = op inside {BRANCH, STORE, OP};
        wr = op inside {LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP};
        free_busy = m_busy;
        if (wbv) free_busy[wbrd] = 0;
        haz = v && ((r1 && rs1 != 0 && free_busy[rs1]) || (r2 && rs2 != 0 && free_busy[rs2]) ||
                    (wr && rd != 0 && free_busy[rd]));
        e_flush = !rst && (red || m_flush_rem > 0);
        e_stall = !rst && !e_flush && haz;
        e_issue = !rst && !e_flush && !haz && v;
        e_busy  = '0;
        for (int i = 1; i < 32; i++) e_busy[i] = m_busy[i];
        s_issue = bus.issue_o;
        s_stall = bus.stall_o;
        s_flush = bus.flush_o;
        s_busy  = bus.busy_o;
        s_cnt   = bus.stall_cnt_o;
        check("issue", 32'(s_issue), 32'(e_issue));
        check("stall", 32'(s_stall), 32'(e_stall));
        check("flush", 32'(s_flush), 32'(e_flush));
        check("busy", s_busy, e_busy);
        check("stall_cnt", 32'(s_cnt), 32'(m_scnt));
        if (rst) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            m_flush_rem = 0;
            m_scnt      = 0;
        end else begin
            m_busy = free_busy;
            if (e_issue && wr && rd != 0) m_busy[rd] = 1;
            if (red) m_flush_rem = FC;
            else if (m_flush_rem > 0) m_flush_rem--;
            if (e_stall && m_scnt < (1 << CW) - 1) m_scnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit red = 0);
        step(0, SYSTEM, 0, 0, 0, 0, 0, red);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        rst = 1'b0;
    endtask

    initial begin
        logic [6:0] ops[11];
        int pick, wrd;
        ops = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, SYSTEM, FENCE};

        do_reset();
        idle();
        check("lit_reset_busy", s_busy, 32'h0);
        check("lit_reset_cnt", 32'(s_cnt), 32'd0);

        // Load-use: three stall cycles, then issue on the writeback bypass.
        step(1, LOAD, 5, 1, 0);
        check("lit_load_issue", 32'(s_issue), 32'd1);
        repeat (3) begin
            step(1, OP, 6, 5, 2);
            check("lit_loaduse_stall", 32'(s_stall), 32'd1);
        end
        step(1, OP, 6, 5, 2, 1, 5);
        check("lit_bypass_issue", 32'(s_issue), 32'd1);
        idle();
        check("lit_loaduse_cnt", 32'(s_cnt), 32'd3);
        check("lit_loaduse_busy", s_busy, 32'h40);

        // x0 never busy; LUI ignores its rs2 field.
        do_reset();
        step(1, OPIMM, 0, 0, 0);
        step(1, OPIMM, 7, 1, 0);
        step(1, LUI, 3, 0, 7);
        check("lit_lui_issue", 32'(s_issue), 32'd1);
        check("lit_lui_busy", s_busy, 32'h80);
        idle();
        check("lit_x0_busy", s_busy, 32'h88);

        // WAW stall, then same-cycle clear and set keeps the bit.
        do_reset();
        step(1, OPIMM, 9, 1, 0);
        step(1, OP, 9, 1, 2);
        check("lit_waw_stall", 32'(s_stall), 32'd1);
        step(1, OP, 9, 1, 2, 1, 9);
        check("lit_setclr_issue", 32'(s_issue), 32'd1);
        idle();
        check("lit_setclr_busy", s_busy, 32'h200);

        // Redirect beats stall; flush lasts FC+1 cycles, extended by a second redirect.
        do_reset();
        step(1, OPIMM, 4, 1, 0);
        step(1, OP, 8, 4, 0, 0, 0, 1);
        check("lit_red_flush", 32'(s_flush), 32'd1);
        check("lit_red_stall", 32'(s_stall), 32'd0);
        step(1, OP, 8, 4, 0);
        check("lit_flush2", 32'(s_flush), 32'd1);
        step(1, OP, 8, 4, 0);
        check("lit_flush_done", 32'(s_flush), 32'd0);
        check("lit_resume_stall", 32'(s_stall), 32'd1);
        idle(1);
        idle(1);
        idle();
        check("lit_ext_flush", 32'(s_flush), 32'd1);
        idle();
        check("lit_ext_done", 32'(s_flush), 32'd0);

        // Reset in the middle of a flush with busy registers pending.
        do_reset();
        step(1, OPIMM, 5, 1, 0);
        step(1, OPIMM, 8, 1, 0);
        idle(1);
        check("lit_pre_rst_busy", s_busy, 32'h120);
        rst = 1'b1;
        step(1, OP, 1, 5, 8);
        check("lit_rst_flush", 32'(s_flush), 32'd0);
        check("lit_rst_stall", 32'(s_stall), 32'd0);
        rst = 1'b0;
        idle();
        check("lit_post_rst_busy", s_busy, 32'h0);
        check("lit_post_rst_flush", 32'(s_flush), 32'd0);

        // Saturation at 2**CW-1.
        do_reset();
        step(1, OPIMM, 4, 1, 0);
        repeat (20) step(1, OP, 1, 4, 0);
        idle();
        check("lit_sat_cnt", 32'(s_cnt), 32'd15);

        // Random traffic over a small register window to provoke hazards.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(0, 299) == 0);
            pick = $urandom_range(0, 10);
            wrd  = $urandom_range(0, 7);
            if ($urandom_range(0, 2) != 0) begin
                for (int k = 0; k < 8; k++) if (m_busy[(wrd + k) % 8]) begin
                    wrd = (wrd + k) % 8;
                    break;
                end
            end
            step($urandom_range(0, 3) != 0, ops[pick], $urandom_range(0, 7),
                 $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1) == 1, wrd,
                 $urandom_range(0, 11) == 0);
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the in-order RV32I core. It sits beside the decode stage and decides each cycle whether the decoded instruction issues to execute, stalls in decode, or is squashed. It tracks pending register writes in a 31-entry busy scoreboard, with x0 never busy, and detects RAW and WAW hazards. It also runs a flush sequence after an execute-stage redirect (taken branch or jump).

Parameters:
FLUSH_CYCLES, 1, extra cycles `flush_o` stays high after the redirect cycle; covers fetch latency; range 0..7
CNT_W, 32, width of the saturating stall-cycle performance counter

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
dec_valid_i  in  1  decode stage holds a valid instruction
dec_opcode_i  in  7  opcode of decode-stage instruction
dec_rd_i  in  5  destination register ID
dec_rs1_i  in  5  source 1 register ID
dec_rs2_i  in  5  source 2 register ID
wb_valid_i  in  1  writeback stage writes a register this cycle
wb_rd_i  in  5  register written by writeback
ex_redirect_i  in  1  execute resolved a taken branch or jump this cycle
issue_o  out  1  decode instruction advances to execute at this clock edge
stall_o  out  1  hold PC and decode registers; inject bubble into execute
flush_o  out  1  squash fetch and decode contents (replace with NOP)
busy_o  out  32  scoreboard state; bit 0 always 0
stall_cnt_o  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (`rst` high at posedge):
  - `busy` cleared to 0; FSM goes to RUN; flush counter 0; `stall_cnt_o` 0.
  - While `rst` is high, `issue_o`, `stall_o` and `flush_o` are forced to 0.
  - Reset mid-flush or mid-stall abandons the operation; there is no pending state after reset.
- Opcode usage decode (combinational):
  - rs1 used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - rs2 used by BRANCH, STORE, OP.
  - rd written by LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP.
  - SYSTEM, FENCE and unknown opcodes use nothing and write nothing.
  - Register 0 is never a hazard source and is never marked busy.
- Effective busy (combinational): `eff_busy = busy & ~(wb_valid_i ? onehot(wb_rd_i) : 0)`. A register written back this cycle counts as free, because the register file bypasses write-before-read.
- Hazard = `dec_valid_i` and any of the following, evaluated on `eff_busy`:
  - rs1 is used and busy;
  - rs2 is used and busy;
  - rd is written and busy (WAW).
- FSM states: RUN, FLUSH.
- In RUN:
  - If `ex_redirect_i`: `flush_o=1`, `issue_o=0`, `stall_o=0`. If `FLUSH_CYCLES>0`, go to FLUSH and load the counter with `FLUSH_CYCLES`; otherwise stay in RUN.
  - Otherwise, if hazard: `stall_o=1`, `issue_o=0`.
  - Otherwise: `issue_o = dec_valid_i`.
- In FLUSH:
  - `flush_o=1`, `issue_o=0`, `stall_o=0`; the counter decrements each cycle.
  - Return to RUN when the counter reaches 1 and no redirect is present.
  - A redirect arriving in FLUSH reloads the counter to `FLUSH_CYCLES`.
- Redirect has priority over stall in every state.
- Scoreboard update at posedge:
  - `busy_next = eff_busy | (issue_o && writes_rd && rd!=0 ? onehot(rd) : 0)`.
  - If the set and the clear hit the same register in the same cycle, the set wins.
  - Writeback to a non-busy register is ignored.
- Squashed instructions never set busy. Instructions already in execute or later are older than the redirect and always reach writeback, so no busy clear is needed on flush.
- `stall_cnt_o` increments in each cycle where `stall_o=1` and saturates at all-ones.
- Latency: `issue_o`, `stall_o` and `flush_o` are combinational from the inputs and registered state, with zero cycles of latency. Busy bits become visible one cycle after issue.

Test Plan:
- Load-use: issue LOAD with rd=x5, then OP using rs1=x5 → `stall_o=1` every cycle until `wb_valid_i` with `wb_rd_i`=5. In the wb cycle `issue_o=1` (bypass). `stall_cnt_o` equals the number of stall cycles.
- x0 and unused fields: issue `ADDI x0,x0,1`, then `LUI x3` with rs1 field=0 and rs2 field=x7 while x7 is busy → no stall, and `busy_o[0]` stays 0.
- WAW plus same-cycle set/clear: x9 busy, wb clears x9 in the same cycle as OP rd=x9 issues → `issue_o=1` and `busy_o[9]=1` next cycle.
- Redirect during stall: hazard active and `ex_redirect_i=1` → `flush_o=1`, `stall_o=0`, `issue_o=0`. With `FLUSH_CYCLES=1`, `flush_o` is high for exactly 2 cycles, then RUN. A second redirect during FLUSH extends the flush by 1 cycle.
- Reset mid-operation: busy=0x0000_0120, FSM in FLUSH, assert `rst` → next cycle busy=0, RUN, all outputs 0, `stall_cnt_o=0`.
- Counter saturation (`CNT_W=4`): hold a hazard for 20 cycles → `stall_cnt_o` stops at 15.
